// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter stage: next-PC select, exception
// causes and default reset/handler addresses.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALUOUT = 2'd0,
    PCSRC_ALURES = 2'd1,
    PCSRC_EPC    = 2'd2,
    PCSRC_VECTOR = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_TRAP     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_RSVD     = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } cause_e;

  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEF = 16'h0100;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the state machine (master) and pc_unit (slave).
interface pc_unit_if #(parameter int unsigned WIDTH = 16);
  logic             PCWrite;
  logic             PCWriteCond;
  logic [1:0]       PCSource;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             ExcReq;
  logic [1:0]       ExcCause;
  logic             ExcTake;
  logic             RestoreMode;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] EPC;
  logic [1:0]       Cause;
  logic             KernelMode;
  logic             ExcPending;

  modport master (
    output PCWrite, PCWriteCond, PCSource, ALUResult, ALUOut, Zero,
           ExcReq, ExcCause, ExcTake, RestoreMode,
    input  PC, EPC, Cause, KernelMode, ExcPending
  );

  modport slave (
    input  PCWrite, PCWriteCond, PCSource, ALUResult, ALUOut, Zero,
           ExcReq, ExcCause, ExcTake, RestoreMode,
    output PC, EPC, Cause, KernelMode, ExcPending
  );
endinterface

// File: rtl/pc_unit_exc_pending_reg.sv
// Pending-exception latch: first cause wins, masked in kernel mode, external
// requests take precedence over a simultaneous misaligned load.
module exc_pending_reg
  import pc_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req,
  input  cause_e req_cause,
  input  logic   misalign,
  input  logic   kernel,
  input  logic   take,
  output logic   pending,
  output cause_e take_cause
);

  logic   pend_q, pend_d;
  cause_e cause_q, cause_d;

  always_comb begin
    pend_d  = pend_q;
    cause_d = cause_q;
    if (take) begin
      pend_d  = 1'b0;
      cause_d = CAUSE_TRAP;
    end else if (!kernel && !pend_q) begin
      if (req) begin
        pend_d  = 1'b1;
        cause_d = req_cause;
      end else if (misalign) begin
        pend_d  = 1'b1;
        cause_d = CAUSE_MISALIGN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      cause_q <= CAUSE_TRAP;
    end else begin
      pend_q  <= pend_d;
      cause_q <= cause_d;
    end
  end

  assign pending = pend_q;
  // A take with nothing pending is a software trap.
  assign take_cause = pend_q ? cause_q : CAUSE_TRAP;

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC mux, EPC/Cause/kernel-mode registers and the
// exception entry/return sequencing driven by the state machine.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF)
) (
  input logic       CLK,
  input logic       Reset,
  pc_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_PC_AL   = {RESET_PC[WIDTH-1:1], 1'b0};
  localparam logic [WIDTH-1:0] EXC_VECTOR_AL = {EXC_VECTOR[WIDTH-1:1], 1'b0};

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  cause_e           cause_q, cause_d;
  logic             kernel_q, kernel_d;

  logic [WIDTH-1:0] target;
  logic             load_en;
  logic             do_load;
  logic             misalign;
  logic             pending;
  cause_e           take_cause;

  always_comb begin
    target = bus.ALUOut;
    unique case (pc_src_e'(bus.PCSource))
      PCSRC_ALUOUT: target = bus.ALUOut;
      PCSRC_ALURES: target = bus.ALUResult;
      PCSRC_EPC:    target = epc_q;
      PCSRC_VECTOR: target = EXC_VECTOR;
    endcase
  end

  assign load_en = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
  // Only a load that actually lands can raise a misaligned exception.
  assign do_load  = load_en & ~bus.ExcTake & ~bus.RestoreMode;
  assign misalign = do_load & target[0] & ~kernel_q;

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    kernel_d = kernel_q;
    if (bus.ExcTake) begin
      epc_d    = pc_q;
      cause_d  = take_cause;
      pc_d     = EXC_VECTOR_AL;
      kernel_d = 1'b1;
    end else if (bus.RestoreMode) begin
      pc_d     = epc_q;
      kernel_d = 1'b0;
    end else if (load_en) begin
      pc_d = {target[WIDTH-1:1], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q     <= RESET_PC_AL;
      epc_q    <= '0;
      cause_q  <= CAUSE_TRAP;
      kernel_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      kernel_q <= kernel_d;
    end
  end

  // The latch sees the current mode, so requests alongside take/restore drop.
  exc_pending_reg u_pend (
    .clk        (CLK),
    .rst        (Reset),
    .req        (bus.ExcReq),
    .req_cause  (cause_e'(bus.ExcCause)),
    .misalign   (misalign),
    .kernel     (kernel_q),
    .take       (bus.ExcTake),
    .pending    (pending),
    .take_cause (take_cause)
  );

  assign bus.PC         = pc_q;
  assign bus.EPC        = epc_q;
  assign bus.Cause      = cause_q;
  assign bus.KernelMode = kernel_q;
  assign bus.ExcPending = pending;

endmodule

// File: tb/tb_pc_unit.sv
// Directed vectors for pc_unit; expected state is queued per step and a
// monitor compares it one edge later.
module tb_pc_unit;

  logic CLK = 1'b0;
  logic Reset = 1'b0;

  pc_unit_if #(.WIDTH(16)) bus ();

  pc_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        km;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, got, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  always @(posedge CLK) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "PC",         bus.PC,                 e.pc);
      chk(e.name, "EPC",        bus.EPC,                e.epc);
      chk(e.name, "Cause",      {14'd0, bus.Cause},     {14'd0, e.cause});
      chk(e.name, "KernelMode", {15'd0, bus.KernelMode}, {15'd0, e.km});
      chk(e.name, "ExcPending", {15'd0, bus.ExcPending}, {15'd0, e.pend});
    end
  end

  task automatic step(input string nm,
                      input logic rst, input logic pcw, input logic pcwc,
                      input logic [1:0] src, input logic [15:0] res, input logic [15:0] aout,
                      input logic zero, input logic req, input logic [1:0] rc,
                      input logic take, input logic rest,
                      input logic [15:0] e_pc, input logic [15:0] e_epc,
                      input logic [1:0] e_c, input logic e_k, input logic e_p);
    exp_t e;
    @(negedge CLK);
    Reset           = rst;
    bus.PCWrite     = pcw;
    bus.PCWriteCond = pcwc;
    bus.PCSource    = src;
    bus.ALUResult   = res;
    bus.ALUOut      = aout;
    bus.Zero        = zero;
    bus.ExcReq      = req;
    bus.ExcCause    = rc;
    bus.ExcTake     = take;
    bus.RestoreMode = rest;
    e.name = nm; e.pc = e_pc; e.epc = e_epc; e.cause = e_c; e.km = e_k; e.pend = e_p;
    sb.push_back(e);
  endtask

  initial begin
    bus.PCWrite = 0; bus.PCWriteCond = 0; bus.PCSource = 0; bus.ALUResult = 0;
    bus.ALUOut = 0; bus.Zero = 0; bus.ExcReq = 0; bus.ExcCause = 0;
    bus.ExcTake = 0; bus.RestoreMode = 0;

    //    name             rst pcw pcwc src res      aout     z  req rc take rst  | PC       EPC      C  K  P
    step("reset",           1, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 0);
    step("load_alures",     0, 1, 0, 2'd1, 16'h0002, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0002, 16'h0000, 2'd0, 0, 0);
    step("cond_zero0",      0, 0, 1, 2'd0, 16'h0000, 16'h0040, 0, 0, 2'd0, 0, 0, 16'h0002, 16'h0000, 2'd0, 0, 0);
    step("cond_zero1",      0, 0, 1, 2'd0, 16'h0000, 16'h0040, 1, 0, 2'd0, 0, 0, 16'h0040, 16'h0000, 2'd0, 0, 0);
    step("load_10",         0, 1, 0, 2'd1, 16'h0010, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0010, 16'h0000, 2'd0, 0, 0);
    step("req_ext",         0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd1, 0, 0, 16'h0010, 16'h0000, 2'd0, 0, 1);
    step("take_ext",        0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0010, 2'd1, 1, 0);
    step("restore_ext",     0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 1, 16'h0010, 16'h0010, 2'd1, 0, 0);
    step("misalign_user",   0, 1, 0, 2'd1, 16'h0023, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0022, 16'h0010, 2'd1, 0, 1);
    step("take_misalign",   0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0022, 2'd3, 1, 0);
    step("misalign_kernel", 0, 1, 0, 2'd1, 16'h0023, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0022, 16'h0022, 2'd3, 1, 0);
    step("req_masked",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd2, 0, 0, 16'h0022, 16'h0022, 2'd3, 1, 0);
    step("restore_req",     0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd1, 0, 1, 16'h0022, 16'h0022, 2'd3, 0, 0);
    step("req_with_take",   0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd1, 1, 0, 16'h0100, 16'h0022, 2'd0, 1, 0);
    step("restore_trap",    0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 1, 16'h0022, 16'h0022, 2'd0, 0, 0);
    step("load_aluout",     0, 1, 0, 2'd0, 16'h0000, 16'h0030, 0, 0, 2'd0, 0, 0, 16'h0030, 16'h0022, 2'd0, 0, 0);
    step("load_src_epc",    0, 1, 0, 2'd2, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0022, 16'h0022, 2'd0, 0, 0);
    step("load_src_vec",    0, 1, 0, 2'd3, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0100, 16'h0022, 2'd0, 0, 0);
    step("take_with_pcw",   0, 1, 0, 2'd1, 16'h0044, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0100, 2'd0, 1, 0);
    step("restore_vec",     0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 1, 16'h0100, 16'h0100, 2'd0, 0, 0);
    step("load_50",         0, 1, 0, 2'd1, 16'h0050, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0050, 16'h0100, 2'd0, 0, 0);
    step("req_cause1",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd1, 0, 0, 16'h0050, 16'h0100, 2'd0, 0, 1);
    step("req_cause2",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd2, 0, 0, 16'h0050, 16'h0100, 2'd0, 0, 1);
    step("misalign_pend",   0, 1, 0, 2'd1, 16'h0061, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0060, 16'h0100, 2'd0, 0, 1);
    step("take_first",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0060, 2'd1, 1, 0);
    step("restore_60",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 1, 16'h0060, 16'h0060, 2'd1, 0, 0);
    step("req_and_mis",     0, 1, 0, 2'd1, 16'h0071, 16'h0000, 0, 1, 2'd2, 0, 0, 16'h0070, 16'h0060, 2'd1, 0, 1);
    step("take_ext_wins",   0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0070, 2'd2, 1, 0);
    step("restore_70",      0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 1, 16'h0070, 16'h0070, 2'd2, 0, 0);
    step("req_pre_reset",   0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 2'd1, 0, 0, 16'h0070, 16'h0070, 2'd2, 0, 1);
    step("reset_pending",   1, 1, 0, 2'd1, 16'h0080, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 0);
    step("load_12",         0, 1, 0, 2'd1, 16'h0012, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0012, 16'h0000, 2'd0, 0, 0);
    step("trap_take",       0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0100, 16'h0012, 2'd0, 1, 0);
    step("reset_kernel",    1, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 1, 0, 16'h0000, 16'h0000, 2'd0, 0, 0);
    step("idle",            0, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 0, 16'h0000, 16'h0000, 2'd0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
